// File: rtl/monster_framebuf_if.sv
// Bus bundle between the pixel writer / matrix scanner and monster_framebuf.
// The design attaches to the slave modport; the driving side uses master.
interface monster_framebuf_if;
  logic       wr_en;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_rgb;
  logic       clr_req;
  logic       swap_req;
  logic       frame_end;
  logic       rd_en;
  logic [3:0] rd_row;
  logic [5:0] rd_col;
  logic [2:0] rgb0;
  logic [2:0] rgb1;
  logic       busy;
  logic       swap_ack;

  modport master (
    output wr_en, wr_x, wr_y, wr_rgb, clr_req, swap_req, frame_end,
    output rd_en, rd_row, rd_col,
    input  rgb0, rgb1, busy, swap_ack
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_rgb, clr_req, swap_req, frame_end,
    input  rd_en, rd_row, rd_col,
    output rgb0, rgb1, busy, swap_ack
  );
endinterface

// File: rtl/monster_framebuf.sv
// Double-buffered 64x32 RGB111 framebuffer for a HUB75-style LED matrix.
// Writes and clears go to the back bank; the scanner reads only the front bank.
module monster_framebuf (
  input  logic                clk,
  input  logic                rst,
  monster_framebuf_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SWAP  = 2'd2;

  logic [1:0]  r_state;
  logic        r_front_sel;
  logic [10:0] r_clr_cnt;
  logic        r_busy;
  logic        r_swap_ack;
  logic [2:0]  r_rgb0;
  logic [2:0]  r_rgb1;

  // Both banks share one array; the top address bit is the bank select.
  logic [2:0]  r_mem [0:4095];

  logic [1:0]  w_state_nxt;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [2:0]  w_wdata;
  logic        w_swap_fire;

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = {~r_front_sel, bus.wr_y, bus.wr_x};
    w_wdata     = bus.wr_rgb;
    w_swap_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        // clr_req outranks both a same-cycle write and a same-cycle swap_req
        if (bus.clr_req) begin
          w_state_nxt = S_CLEAR;
        end else begin
          w_we = bus.wr_en;
          if (bus.swap_req) w_state_nxt = S_SWAP;
        end
      end
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = {~r_front_sel, r_clr_cnt};
        w_wdata = 3'b000;
        if (r_clr_cnt == 11'd2047) w_state_nxt = S_IDLE;
      end
      S_SWAP: begin
        if (bus.frame_end) begin
          w_swap_fire = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_front_sel <= 1'b0;
      r_clr_cnt   <= 11'd0;
      r_busy      <= 1'b0;
      r_swap_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_swap_ack <= w_swap_fire;
      if (w_swap_fire) r_front_sel <= ~r_front_sel;
      if (r_state == S_IDLE && bus.clr_req) r_clr_cnt <= 11'd0;
      else if (r_state == S_CLEAR)          r_clr_cnt <= r_clr_cnt + 11'd1;
    end
  end

  // Bank contents survive reset; software clears explicitly.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb0 <= 3'b000;
      r_rgb1 <= 3'b000;
    end else if (bus.rd_en) begin
      r_rgb0 <= r_mem[{r_front_sel, 1'b0, bus.rd_row, bus.rd_col}];
      r_rgb1 <= r_mem[{r_front_sel, 1'b1, bus.rd_row, bus.rd_col}];
    end
  end

  assign bus.rgb0     = r_rgb0;
  assign bus.rgb1     = r_rgb1;
  assign bus.busy     = r_busy;
  assign bus.swap_ack = r_swap_ack;

endmodule

// File: tb/tb_monster_framebuf.sv
// Directed bench for monster_framebuf: clear, write, swap, read-back and reset-abort scenarios.
module tb_monster_framebuf;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n;

  monster_framebuf_if bus ();

  monster_framebuf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] y, input logic [5:0] x, input logic [2:0] rgb);
    bus.wr_en = 1'b1; bus.wr_y = y; bus.wr_x = x; bus.wr_rgb = rgb;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] row, input logic [5:0] col);
    bus.rd_en = 1'b1; bus.rd_row = row; bus.rd_col = col;
    step();
    bus.rd_en = 1'b0;
  endtask

  // Busy is already high after the request edge; count further cycles until it drops.
  task automatic wait_clear(input string tag);
    n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chkn(tag, n, 2048);
  endtask

  task automatic do_clear(input string tag);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    chk1({tag, "_busy_hi"}, bus.busy, 1'b1);
    wait_clear({tag, "_len"});
  endtask

  task automatic do_swap(input string tag);
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    chk1({tag, "_pend_busy"}, bus.busy, 1'b1);
    step();
    chk1({tag, "_no_early_ack"}, bus.swap_ack, 1'b0);
    bus.frame_end = 1'b1;
    step();
    bus.frame_end = 1'b0;
    chk1({tag, "_ack"}, bus.swap_ack, 1'b1);
    chk1({tag, "_idle"}, bus.busy, 1'b0);
    step();
    chk1({tag, "_ack_pulse"}, bus.swap_ack, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
    bus.clr_req = 1'b0; bus.swap_req = 1'b0; bus.frame_end = 1'b0;
    bus.rd_en = 1'b0; bus.rd_row = '0; bus.rd_col = '0;

    step(); step();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ack", bus.swap_ack, 1'b0);
    chk3("rst_rgb0", bus.rgb0, 3'b000);
    chk3("rst_rgb1", bus.rgb1, 3'b000);
    rst = 1'b1;
    step();

    // Clear both banks so every later read is deterministic.
    do_clear("clr1");
    do_swap("swap1");
    rd(4'd0, 6'd0);
    chk3("zero_rgb0_a", bus.rgb0, 3'b000);
    chk3("zero_rgb1_a", bus.rgb1, 3'b000);
    rd(4'd15, 6'd63);
    chk3("zero_rgb0_b", bus.rgb0, 3'b000);
    chk3("zero_rgb1_b", bus.rgb1, 3'b000);
    do_clear("clr2");
    do_swap("swap2");

    wr(5'd3, 6'd5, 3'b100);
    wr(5'd19, 6'd5, 3'b010);
    do_swap("swap3");
    rd(4'd3, 6'd5);
    chk3("pix_rgb0", bus.rgb0, 3'b100);
    chk3("pix_rgb1", bus.rgb1, 3'b010);
    bus.rd_row = 4'd0; bus.rd_col = 6'd0;
    step();
    chk3("hold_rgb0", bus.rgb0, 3'b100);
    chk3("hold_rgb1", bus.rgb1, 3'b010);

    wr(5'd3, 6'd5, 3'b111);
    rd(4'd3, 6'd5);
    chk3("back_hidden", bus.rgb0, 3'b100);
    do_swap("swap4");
    rd(4'd3, 6'd5);
    chk3("back_shown0", bus.rgb0, 3'b111);
    chk3("back_shown1", bus.rgb1, 3'b000);

    // clr_req beats a same-cycle swap_req; the later frame_end must do nothing.
    bus.clr_req = 1'b1; bus.swap_req = 1'b1;
    step();
    bus.clr_req = 1'b0; bus.swap_req = 1'b0;
    chk1("clrsw_busy", bus.busy, 1'b1);
    wait_clear("clrsw_len");
    bus.frame_end = 1'b1;
    step();
    bus.frame_end = 1'b0;
    chk1("clrsw_no_ack0", bus.swap_ack, 1'b0);
    step();
    chk1("clrsw_no_ack1", bus.swap_ack, 1'b0);
    chk1("clrsw_idle", bus.busy, 1'b0);
    rd(4'd3, 6'd5);
    chk3("clrsw_front", bus.rgb0, 3'b111);

    // Write during SWAP_PEND is dropped; back (3,5) stays cleared.
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    wr(5'd3, 6'd5, 3'b001);
    bus.frame_end = 1'b1;
    step();
    bus.frame_end = 1'b0;
    chk1("pend_ack", bus.swap_ack, 1'b1);
    rd(4'd3, 6'd5);
    chk3("pend_wr_dropped", bus.rgb0, 3'b000);

    // swap_req together with frame_end waits for the next frame_end.
    bus.swap_req = 1'b1; bus.frame_end = 1'b1;
    step();
    bus.swap_req = 1'b0; bus.frame_end = 1'b0;
    chk1("same_busy", bus.busy, 1'b1);
    chk1("same_no_ack0", bus.swap_ack, 1'b0);
    step();
    chk1("same_no_ack1", bus.swap_ack, 1'b0);
    bus.frame_end = 1'b1;
    step();
    bus.frame_end = 1'b0;
    chk1("same_ack", bus.swap_ack, 1'b1);
    rd(4'd3, 6'd5);
    chk3("same_front", bus.rgb0, 3'b111);

    // Reset asserted mid-clear acts immediately, without a clock edge.
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 1000; i++) step();
    chk1("mid_busy", bus.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("arst_busy", bus.busy, 1'b0);
    chk3("arst_rgb0", bus.rgb0, 3'b000);
    chk3("arst_rgb1", bus.rgb1, 3'b000);
    step();
    rst = 1'b1;
    bus.frame_end = 1'b1;
    step();
    bus.frame_end = 1'b0;
    chk1("arst_no_ack0", bus.swap_ack, 1'b0);
    step();
    chk1("arst_no_ack1", bus.swap_ack, 1'b0);
    chk1("arst_idle", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
